// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the sync_fifo read-side streamer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam int DEF_DW = 64;
  localparam int DEF_CW = 16;

  // Wide enough for occ + in-flight reads + the read strobe currently on the wire.
  function automatic int credit_w(input int buf_depth, input int rd_lat);
    return $clog2(buf_depth + rd_lat + 2);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Circular output buffer: captured FIFO words wait here until the consumer takes them.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = 2,
  parameter int OCW   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [DW-1:0]  push_data,
  output logic           valid,
  output logic [DW-1:0]  data,
  input  logic           ready,
  output logic [OCW-1:0] occ,
  output logic           full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Transfer happens on any cycle with valid & ready; data holds while valid & !ready.
  assign valid   = (occ != '0);
  assign full    = (occ == OCW'(DEPTH));
  assign data    = mem[head];
  assign do_pop  = valid & ready;
  assign do_push = push & ~full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_data;
        tail      <= next_ptr(tail);
      end
      if (do_pop) head <= next_ptr(head);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCW'(1);
        2'b01:   occ <= occ - OCW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains sync_fifo's read port into a valid/ready stream, issuing reads only with buffer credit.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 2,
  parameter int BACKOFF   = 4,
  parameter int CW        = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_fifo_rden,
  input  logic [DW-1:0] i_fifo_data,
  input  logic          i_fifo_data_vld,
  input  logic          i_fifo_underflow,
  output logic [DW-1:0] o_m_data,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic          o_busy,
  output logic [CW-1:0] o_empty_cnt,
  output logic          o_proto_err,
  output state_t        o_state
);

  localparam int OCW = credit_w(BUF_DEPTH, RD_LAT);
  localparam int BW  = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam logic [BW-1:0] BO_LOAD = BW'((BACKOFF > 0) ? BACKOFF - 1 : 0);

  state_t          state;
  state_t          state_d;
  logic [RD_LAT-1:0] sr;
  logic [BW-1:0]   bo_cnt;
  logic [BW-1:0]   bo_cnt_d;
  logic [OCW-1:0]  occ;
  logic [OCW-1:0]  sr_cnt;
  logic [OCW-1:0]  credit_sum;
  logic            credit;
  logic            full;
  logic            pop;
  logic            tail;
  logic            capture;
  logic            under_evt;
  logic            resp_err;
  logic            rden_d;

  always_comb begin
    sr_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) sr_cnt = sr_cnt + OCW'(sr[i]);
  end

  // The strobe on the wire this cycle is not yet in sr, so it is charged against credit too.
  assign tail       = sr[RD_LAT-1];
  assign pop        = o_m_valid & i_m_ready;
  assign credit_sum = occ + sr_cnt + OCW'(o_fifo_rden) - OCW'(pop);
  assign credit     = (credit_sum < OCW'(BUF_DEPTH));

  assign under_evt = tail & i_fifo_underflow & ~i_fifo_data_vld;
  assign capture   = tail & i_fifo_data_vld & ~i_fifo_underflow & ~full;
  assign resp_err  = (~tail & (i_fifo_data_vld | i_fifo_underflow))
                   | (tail & (i_fifo_data_vld == i_fifo_underflow))
                   | (tail & i_fifo_data_vld & ~i_fifo_underflow & full);

  always_comb begin
    state_d  = state;
    bo_cnt_d = bo_cnt;
    rden_d   = 1'b0;
    case (state)
      ST_IDLE: if (i_en) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (under_evt && (BACKOFF != 0)) begin
          state_d  = ST_BACKOFF;
          bo_cnt_d = BO_LOAD;
        end else if (!i_en) begin
          state_d = ST_DRAIN;
        end else begin
          rden_d = credit;
        end
      end
      ST_BACKOFF: begin
        if (under_evt)             bo_cnt_d = BO_LOAD;
        else if (bo_cnt == '0)     state_d  = i_en ? ST_ISSUE : ST_DRAIN;
        else                       bo_cnt_d = bo_cnt - BW'(1);
      end
      ST_DRAIN: if ((sr_cnt == '0) && !o_fifo_rden) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      sr          <= '0;
      bo_cnt      <= '0;
      o_fifo_rden <= 1'b0;
      o_empty_cnt <= '0;
      o_proto_err <= 1'b0;
    end else begin
      state       <= state_d;
      sr          <= RD_LAT'({sr, o_fifo_rden});
      bo_cnt      <= bo_cnt_d;
      o_fifo_rden <= rden_d;
      if (under_evt && (o_empty_cnt != '1)) o_empty_cnt <= o_empty_cnt + CW'(1);
      if (resp_err) o_proto_err <= 1'b1;
    end
  end

  fifo_rd_skid #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH),
    .OCW   (OCW)
  ) u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (capture),
    .push_data (i_fifo_data),
    .valid     (o_m_valid),
    .data      (o_m_data),
    .ready     (i_m_ready),
    .occ       (occ),
    .full      (full)
  );

  assign o_busy  = (sr_cnt != '0) | o_fifo_rden | o_m_valid | (state != ST_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a one-cycle-latency sync_fifo read-port model.
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  localparam int DW = 64;
  localparam int CW = 16;

  logic          tb2dut_clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_rden;
  logic [DW-1:0] fifo_data;
  logic          fifo_vld;
  logic          fifo_und;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic [CW-1:0] empty_cnt;
  logic          proto_err;
  state_t        dbg_state;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  logic          inject = 1'b0;

  always #5 tb2dut_clk = ~tb2dut_clk;

  fifo_rd_stream dut (
    .i_clk            (tb2dut_clk),
    .i_rst            (rst),
    .i_en             (en),
    .o_fifo_rden      (fifo_rden),
    .i_fifo_data      (fifo_data),
    .i_fifo_data_vld  (fifo_vld),
    .i_fifo_underflow (fifo_und),
    .o_m_data         (m_data),
    .o_m_valid        (m_valid),
    .i_m_ready        (m_ready),
    .o_busy           (busy),
    .o_empty_cnt      (empty_cnt),
    .o_proto_err      (proto_err),
    .o_state          (dbg_state)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score any transfer, cross the edge, then answer the read seen before the edge.
  task automatic tick();
    logic rd;
    rd = fifo_rden;
    if (m_valid && m_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) begin
        n_pass++;
      end else begin
        $error("FAIL sb_unexpected_pop: observed %0h expected no word", m_data);
      end
      if (exp_q.size() != 0) check("sb_data", m_data, exp_q.pop_front());
    end
    @(posedge tb2dut_clk);
    #1;
    cyc++;
    fifo_vld  = 1'b0;
    fifo_und  = 1'b0;
    fifo_data = '0;
    if (rd) begin
      if (fifo_q.size() != 0) begin
        fifo_data = fifo_q.pop_front();
        fifo_vld  = 1'b1;
      end else begin
        fifo_und = 1'b1;
      end
    end
    if (inject) begin
      fifo_vld  = 1'b1;
      fifo_data = 64'hdead;
      inject    = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && (busy || dbg_state != ST_IDLE); k++) tick();
    check(tag, DW'(busy), 64'd0);
  endtask

  initial begin
    int   rd_cyc;
    int   rd_cnt;
    logic stable;

    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    fifo_vld = 1'b0; fifo_und = 1'b0; fifo_data = '0;
    repeat (2) @(posedge tb2dut_clk);
    #1;
    check("rst_rden",      DW'(fifo_rden), 64'd0);
    check("rst_valid",     DW'(m_valid),   64'd0);
    check("rst_data",      m_data,         64'd0);
    check("rst_busy",      DW'(busy),      64'd0);
    check("rst_empty_cnt", DW'(empty_cnt), 64'd0);
    check("rst_proto_err", DW'(proto_err), 64'd0);
    check("rst_state",     DW'(dbg_state), DW'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Stream three words, then the poll that finds the FIFO empty.
    fifo_q = '{64'h11, 64'h22, 64'h33};
    exp_q  = '{64'h11, 64'h22, 64'h33};
    en = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 10 && !fifo_rden; k++) tick();
    check("t1_rden_seen", DW'(fifo_rden), 64'd1);
    rd_cyc = cyc;
    for (int k = 0; k < 10 && !m_valid; k++) tick();
    check("t1_valid_latency", DW'(cyc - rd_cyc), 64'd2);
    check("t1_first_word", m_data, 64'h11);
    check("t3_occ_at_capture_pop", DW'(dut.occ), 64'd1);
    tick();
    check("t3_head_advanced", m_data, 64'h22);
    check("t3_valid_kept", DW'(m_valid), 64'd1);
    check("t3_occ_unchanged", DW'(dut.occ), 64'd1);
    for (int k = 0; k < 10 && !fifo_und; k++) tick();
    check("t1_underflow_seen", DW'(fifo_und), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_backoff_no_rden", DW'(fifo_rden), 64'd0);
    end
    check("t1_empty_cnt", DW'(empty_cnt), 64'd1);
    check("t1_all_words", DW'(exp_q.size()), 64'd0);
    en = 1'b0;
    wait_idle("t1_idle");

    // Backpressure: credit must cap outstanding reads at the buffer depth.
    fifo_q = '{64'ha1, 64'ha2, 64'ha3, 64'ha4, 64'ha5};
    exp_q  = '{64'ha1, 64'ha2, 64'ha3, 64'ha4, 64'ha5};
    m_ready = 1'b0; en = 1'b1; rd_cnt = 0; stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (fifo_rden) rd_cnt++;
      if (m_valid && (m_data !== 64'ha1)) stable = 1'b0;
    end
    check("t2_reads_issued", DW'(rd_cnt),    64'd2);
    check("t2_head_valid",   DW'(m_valid),   64'd1);
    check("t2_head_stable",  DW'(stable),    64'd1);
    check("t2_occ_full",     DW'(dut.occ),   64'd2);
    check("t2_no_proto_err", DW'(proto_err), 64'd0);
    m_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    check("t2_all_delivered", DW'(exp_q.size()), 64'd0);
    en = 1'b0;
    wait_idle("t2_idle");
    check("t2_no_proto_err_end", DW'(proto_err), 64'd0);

    // Disable with one read on the wire.
    fifo_q = '{64'hc1, 64'hc2, 64'hc3};
    exp_q  = '{64'hc1, 64'hc2, 64'hc3};
    m_ready = 1'b1; en = 1'b1;
    for (int k = 0; k < 10 && !fifo_rden; k++) tick();
    check("t4_rden_seen", DW'(fifo_rden), 64'd1);
    en = 1'b0;
    tick();
    check("t4_drain_state", DW'(dbg_state), DW'(ST_DRAIN));
    rd_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (fifo_rden) rd_cnt++;
      tick();
    end
    check("t4_no_new_rden", DW'(rd_cnt),       64'd0);
    check("t4_idle_state",  DW'(dbg_state),    DW'(ST_IDLE));
    check("t4_busy_low",    DW'(busy),         64'd0);
    check("t4_one_word",    DW'(exp_q.size()), 64'd2);
    fifo_q.delete();
    exp_q.delete();

    // Response with no read outstanding.
    inject = 1'b1;
    tick();
    tick();
    check("t5_proto_err_set", DW'(proto_err), 64'd1);
    check("t5_no_capture",    DW'(dut.occ),   64'd0);
    repeat (3) tick();
    check("t5_proto_err_sticky", DW'(proto_err), 64'd1);

    // Async reset with two words buffered.
    fifo_q = '{64'hd1, 64'hd2, 64'hd3, 64'hd4};
    exp_q  = '{64'hd1, 64'hd2, 64'hd3, 64'hd4};
    m_ready = 1'b0; en = 1'b1;
    for (int k = 0; k < 20 && dut.occ != 2; k++) tick();
    check("t6_occ2", DW'(dut.occ), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid",     DW'(m_valid),   64'd0);
    check("t6_rst_rden",      DW'(fifo_rden), 64'd0);
    check("t6_rst_empty_cnt", DW'(empty_cnt), 64'd0);
    check("t6_rst_proto_err", DW'(proto_err), 64'd0);
    check("t6_rst_state",     DW'(dbg_state), DW'(ST_IDLE));
    @(posedge tb2dut_clk);
    #1;
    cyc++;
    rst = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    m_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    check("t6_resumed", DW'(exp_q.size()), 64'd0);
    check("t6_no_proto_err", DW'(proto_err), 64'd0);
    en = 1'b0;
    wait_idle("t6_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
